// File: rtl/level_debouncer.sv
// level_debouncer: six-bit level-switch debouncer with a startup sequence,
// a change pulse and a sticky detector for non-contiguous fill patterns.
module level_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] SwRaw,
  input  logic       ErrClr,
  output logic [5:0] Levels,
  output logic       LevelsValid,
  output logic       Changed,
  output logic       FillError
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX       = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_INIT_LAST = CNT_W'(1);

  // A level above an empty level means a stuck or broken sensor.
  function automatic logic fill_fault(input logic [5:0] lv);
    logic f;
    f = 1'b0;
    for (int i = 1; i < 6; i++) begin
      if (lv[i] && !lv[i-1]) f = 1'b1;
    end
    return f;
  endfunction

  logic [5:0]       r_sync_p0;
  logic [5:0]       r_sync_p1;
  logic [CNT_W-1:0] r_cnt [6];
  logic [5:0]       r_levels;
  logic [5:0]       w_upd;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W-1:0] w_tmr_nxt;
  logic             r_upd_p2;
  logic             r_changed;
  logic             r_fill_err;
  logic             w_fault;

  assign Levels      = r_levels;
  assign LevelsValid = (r_state == ST_RUN);
  assign Changed     = r_changed;
  assign FillError   = r_fill_err;
  assign w_fault     = fill_fault(r_levels);

  // Stage p0/p1: two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= SwRaw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Per-bit acceptance: the bit flips on the edge its mismatch count is full.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < 6; i++) begin
      w_upd[i] = (r_state != ST_INIT) && (r_sync_p1[i] != r_levels[i]) &&
                 (r_cnt[i] == LP_MAX);
    end
  end

  // Debounce counters and the accepted level vector; any matching edge restarts a count.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
      r_levels <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if ((r_state == ST_INIT) || (r_sync_p1[i] == r_levels[i]) || w_upd[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + LP_ONE;
      end
      r_levels <= (r_levels & ~w_upd) | (r_sync_p1 & w_upd);
    end
  end

  // Startup sequencer state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_INIT;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Startup sequencer: fill synchronizers, let the engine settle once, then run forever.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      ST_INIT: begin
        if (r_tmr == LP_INIT_LAST) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + LP_ONE;
        end
      end
      ST_SETTLE: begin
        if (r_tmr == LP_MAX) begin
          w_state_nxt = ST_RUN;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + LP_ONE;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_tmr_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // Stage p2: change pulse one edge after an update in RUN, and the sticky fill-fault flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_upd_p2   <= 1'b0;
      r_changed  <= 1'b0;
      r_fill_err <= 1'b0;
    end else begin
      r_upd_p2  <= (r_state == ST_RUN) && (|w_upd);
      r_changed <= r_upd_p2;
      if ((r_state == ST_RUN) && w_fault)
        r_fill_err <= 1'b1;
      else if (ErrClr && !w_fault)
        r_fill_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_level_debouncer.sv
// Directed bench for level_debouncer with DEBOUNCE_CYCLES=4.
module tb_level_debouncer;

  logic       Clk;
  logic       Rst;
  logic [5:0] SwRaw;
  logic       ErrClr;
  logic [5:0] Levels;
  logic       LevelsValid;
  logic       Changed;
  logic       FillError;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [8:0] v;   // {Levels, LevelsValid, Changed, FillError}
  } exp_t;

  exp_t q[$];

  level_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .Clk(Clk), .Rst(Rst), .SwRaw(SwRaw), .ErrClr(ErrClr),
    .Levels(Levels), .LevelsValid(LevelsValid), .Changed(Changed),
    .FillError(FillError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [5:0] lv, input logic vld,
                      input logic ch, input logic fe);
    exp_t e;
    e.tag = tag;
    e.v   = {lv, vld, ch, fe};
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [8:0] obs;
    e   = q.pop_front();
    obs = {Levels, LevelsValid, Changed, FillError};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.v);
    end
  endtask

  // One clock: expectation queued with the stimulus, compared 1 time unit after the edge.
  task automatic tk(input string tag, input logic [5:0] lv, input logic vld,
                    input logic ch, input logic fe);
    push(tag, lv, vld, ch, fe);
    @(posedge Clk);
    #1;
    pop_check();
  endtask

  task automatic startup(input string tag);
    for (int i = 1; i <= 5; i++) tk($sformatf("%s_e%0d", tag, i), 6'b000000, 1'b0, 1'b0, 1'b0);
    tk({tag, "_e6"}, 6'b000111, 1'b1, 1'b0, 1'b0);
    tk({tag, "_e7"}, 6'b000111, 1'b1, 1'b0, 1'b0);
    tk({tag, "_e8"}, 6'b000111, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    Rst    = 1'b1;
    SwRaw  = 6'b000111;
    ErrClr = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    push("reset_state", 6'b000000, 1'b0, 1'b0, 1'b0);
    pop_check();
    Rst = 1'b0;

    // Startup with 000111 held
    startup("start");

    // Clean step on bit 3
    SwRaw = 6'b001111;
    for (int i = 1; i <= 5; i++) tk($sformatf("step_e%0d", i), 6'b000111, 1'b1, 1'b0, 1'b0);
    tk("step_e6", 6'b001111, 1'b1, 1'b0, 1'b0);
    tk("step_e7_pulse", 6'b001111, 1'b1, 1'b1, 1'b0);
    tk("step_e8", 6'b001111, 1'b1, 1'b0, 1'b0);

    // Bouncing bit 4
    for (int i = 0; i < 20; i++) begin
      SwRaw[4] = ~SwRaw[4];
      tk($sformatf("bounce_%0d", i), 6'b001111, 1'b1, 1'b0, 1'b0);
    end
    SwRaw = 6'b001111;
    for (int i = 0; i < 4; i++) tk($sformatf("bounce_after_%0d", i), 6'b001111, 1'b1, 1'b0, 1'b0);

    // Non-contiguous pattern sets the fault
    SwRaw = 6'b100001;
    for (int i = 1; i <= 5; i++) tk($sformatf("fault_e%0d", i), 6'b001111, 1'b1, 1'b0, 1'b0);
    tk("fault_e6", 6'b100001, 1'b1, 1'b0, 1'b0);
    tk("fault_e7_set", 6'b100001, 1'b1, 1'b1, 1'b1);
    tk("fault_e8", 6'b100001, 1'b1, 1'b0, 1'b1);

    // Clear while the fault persists: set wins
    ErrClr = 1'b1;
    tk("clr_blocked", 6'b100001, 1'b1, 1'b0, 1'b1);
    ErrClr = 1'b0;
    tk("clr_blocked_after", 6'b100001, 1'b1, 1'b0, 1'b1);

    // Repair the pattern, then clear
    SwRaw = 6'b000011;
    for (int i = 1; i <= 5; i++) tk($sformatf("fix_e%0d", i), 6'b100001, 1'b1, 1'b0, 1'b1);
    tk("fix_e6", 6'b000011, 1'b1, 1'b0, 1'b1);
    tk("fix_e7", 6'b000011, 1'b1, 1'b1, 1'b1);
    tk("fix_e8_sticky", 6'b000011, 1'b1, 1'b0, 1'b1);
    ErrClr = 1'b1;
    tk("clr_ok", 6'b000011, 1'b1, 1'b0, 1'b0);
    ErrClr = 1'b0;
    tk("clr_ok_after", 6'b000011, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset two cycles into a debounce count on bit 2
    SwRaw = 6'b000111;
    for (int i = 1; i <= 4; i++) tk($sformatf("pre_rst_e%0d", i), 6'b000011, 1'b1, 1'b0, 1'b0);
    #2;
    Rst = 1'b1;
    #1;
    push("async_rst", 6'b000000, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(posedge Clk);
    #1;
    push("rst_held", 6'b000000, 1'b0, 1'b0, 1'b0);
    pop_check();
    Rst = 1'b0;
    startup("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
